// File: rtl/bidir_bus_pkg.sv
// Shared types and default parameters for the bidirectional pin-bus sequencer.
// The optional beat timeout is enabled with `define BIDIR_BUS_TIMEOUT_EN.
package bidir_bus_pkg;

  localparam int unsigned DEF_WIDTH   = 4;
  localparam int unsigned DEF_TURN    = 1;
  localparam int unsigned DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_TURN_BACK = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WR_LO     = 3'd2,
    ST_WR_HI     = 3'd3,
    ST_TURN_RD   = 3'd4,
    ST_RD_LO     = 3'd5,
    ST_RD_HI     = 3'd6,
    ST_DONE      = 3'd7
  } state_e;

  // States in which a nibble beat is strobed to the slave.
  function automatic logic is_beat(input state_e s);
    return (s == ST_WR_LO) || (s == ST_WR_HI) || (s == ST_RD_LO) || (s == ST_RD_HI);
  endfunction

  // States in which the master owns the pins.
  function automatic logic master_drives(input state_e s);
    return (s == ST_IDLE) || (s == ST_WR_LO) || (s == ST_WR_HI) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/bus_turn_timer.sv
// Loadable down-counter with a zero flag; times turnaround gaps and beat stalls.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (reloads RST_VAL)
//   load        - load load_val this cycle (priority over counting)
//   load_val    - value to load
//   done        - counter has reached zero
module bus_turn_timer #(
  parameter int unsigned          CNT_W   = 4,
  parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating decrement; a load restarts the interval.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RST_VAL;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Master-side sequencer for a half-duplex nibble-wide tristate bus. Each byte
// command moves as two nibble beats; turnaround gaps with the pins released
// guarantee master and slave never drive together.
// Optional feature: `define BIDIR_BUS_TIMEOUT_EN aborts beats lacking bus_ack.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   cmd_valid/cmd_ready            - command handshake
//   cmd_write, cmd_wdata           - direction and write byte
//   rsp_valid, rsp_rdata, rsp_err  - one-cycle completion with read byte / timeout flag
//   bus_stb, bus_rw, bus_ack       - beat strobe, direction, slave acknowledge
//   io_out, io_oe, io_in           - pad drive value, pad enable, pad readback
module bidir_bus_ctrl
  import bidir_bus_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TURN    = DEF_TURN,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [2*WIDTH-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [2*WIDTH-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               bus_stb,
  output logic               bus_rw,
  input  logic               bus_ack,
  output logic [WIDTH-1:0]   io_out,
  output logic               io_oe,
  input  logic [WIDTH-1:0]   io_in
);

  localparam int unsigned DW      = 2 * WIDTH;
  localparam int unsigned CNT_MAX = (TIMEOUT > TURN) ? TIMEOUT : TURN;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN - 1);
`ifdef BIDIR_BUS_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT - 1);
`endif

  state_e state_q, state_d;
  logic   rd_back_q, rd_back_d;   // TURN_BACK exits to DONE rather than IDLE
  logic   err_q, err_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic   abort;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  logic               cmd_ready_d, rsp_valid_d, rsp_err_d, bus_stb_d, bus_rw_d, io_oe_d;
  logic [DW-1:0]      rsp_rdata_d;
  logic [WIDTH-1:0]   io_out_d;
  logic               cmd_ready_q, rsp_valid_q, rsp_err_q, bus_stb_q, bus_rw_q, io_oe_q;
  logic [DW-1:0]      rsp_rdata_q;
  logic [WIDTH-1:0]   io_out_q;

  // Reset value TURN-1 so the post-reset TURN_BACK lasts exactly TURN cycles.
  bus_turn_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (TURN_LD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Next-state and command bookkeeping.
  always_comb begin
    state_d   = state_q;
    rd_back_d = rd_back_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    abort     = 1'b0;
`ifdef BIDIR_BUS_TIMEOUT_EN
    abort     = !bus_ack && tmr_done;
`endif
    case (state_q)
      ST_TURN_BACK: if (tmr_done) state_d = rd_back_q ? ST_DONE : ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          wdata_d   = cmd_wdata;
          rdata_d   = '0;
          err_d     = 1'b0;
          rd_back_d = 1'b0;
          state_d   = cmd_write ? ST_WR_LO : ST_TURN_RD;
        end
      end
      ST_WR_LO: begin
        if (bus_ack)    state_d = ST_WR_HI;
        else if (abort) begin err_d = 1'b1; state_d = ST_DONE; end
      end
      ST_WR_HI: begin
        if (bus_ack)    state_d = ST_DONE;
        else if (abort) begin err_d = 1'b1; state_d = ST_DONE; end
      end
      ST_TURN_RD: if (tmr_done) state_d = ST_RD_LO;
      ST_RD_LO: begin
        if (bus_ack) begin
          rdata_d[WIDTH-1:0] = io_in;
          state_d            = ST_RD_HI;
        end else if (abort) begin
          err_d = 1'b1; rd_back_d = 1'b1; state_d = ST_TURN_BACK;
        end
      end
      ST_RD_HI: begin
        if (bus_ack) begin
          rdata_d[DW-1:WIDTH] = io_in;
          rd_back_d           = 1'b1;
          state_d             = ST_TURN_BACK;
        end else if (abort) begin
          err_d = 1'b1; rd_back_d = 1'b1; state_d = ST_TURN_BACK;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_TURN_BACK;
    endcase
  end

  // Timer restarts on every state change: turnaround length or beat stall budget.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = TURN_LD;
`ifdef BIDIR_BUS_TIMEOUT_EN
    if (is_beat(state_d)) tmr_val = TIMEOUT_LD;
`endif
  end

  // Outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    rsp_err_d   = (state_d == ST_DONE) && err_d;
    rsp_rdata_d = ((state_d == ST_DONE) && !err_d) ? rdata_d : '0;
    bus_stb_d   = is_beat(state_d);
    bus_rw_d    = master_drives(state_d);
    io_oe_d     = master_drives(state_d);
    io_out_d    = '0;
    if (state_d == ST_WR_LO) io_out_d = wdata_d[WIDTH-1:0];
    if (state_d == ST_WR_HI) io_out_d = wdata_d[DW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_TURN_BACK;
      rd_back_q   <= 1'b0;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      bus_stb_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      io_oe_q     <= 1'b0;
      io_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      rd_back_q   <= rd_back_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_stb_q   <= bus_stb_d;
      bus_rw_q    <= bus_rw_d;
      io_oe_q     <= io_oe_d;
      io_out_q    <= io_out_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef BIDIR_BUS_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign bus_stb   = bus_stb_q;
  assign bus_rw    = bus_rw_q;
  assign io_oe     = io_oe_q;
  assign io_out    = io_out_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: transaction-level timing model, slave with planned
// ack stalls, and a per-cycle checker run from a single process.
module tb_bidir_bus_ctrl;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned TURN    = 2;
  localparam int unsigned TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_wdata = 8'h00;
  logic       bus_ack = 1'b0;
  logic [3:0] io_in = 4'h0;
  logic       cmd_ready, rsp_valid, rsp_err, bus_stb, bus_rw, io_oe;
  logic [7:0] rsp_rdata;
  logic [3:0] io_out;

  bidir_bus_ctrl #(.WIDTH(WIDTH), .TURN(TURN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_stb(bus_stb), .bus_rw(bus_rw), .bus_ack(bus_ack),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Expectations for the command in flight and reset windows.
  int         exp_rsp  = -1;
  int         oe_lo    = -1;
  int         oe_hi    = -2;
  int         rdy_cyc  = -1;
  int         zero_cyc = -1;
  int         exp_acc  = -1;
  int         acc_cyc  = 0;
  logic       oe_exp   = 1'b0;
  logic       exp_write = 1'b0;
  logic       exp_err  = 1'b0;
  logic [7:0] exp_wdata = 8'h00;
  logic [7:0] exp_rdata = 8'h00;

  // Slave plan: stall cycles and returned nibble per beat.
  int         sl_beat = 0;
  int         sl_wait = 0;
  int         sl_stall [2];
  logic [3:0] sl_nib [2];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // One cycle: sample on the falling edge, check, then play the slave.
  task automatic tick();
    @(negedge clk);
    chk("rsp_valid", int'(rsp_valid), int'(cyc == exp_rsp));
    if (rsp_valid) begin
      chk("rsp_rdata", int'(rsp_rdata), int'(exp_rdata));
      chk("rsp_err", int'(rsp_err), int'(exp_err));
    end
    if (cyc >= oe_lo && cyc <= oe_hi) chk("oe_window", int'(io_oe), int'(oe_exp));
    if (cyc == rdy_cyc) chk("idle_after_reset", int'({cmd_ready, io_oe, io_out}), int'({1'b1, 1'b1, 4'h0}));
    if (cyc == zero_cyc)
      chk("reset_values", int'({cmd_ready, rsp_valid, rsp_err, bus_stb, bus_rw, io_oe, io_out, rsp_rdata}), 0);
    if (cmd_ready) chk("idle_park", int'({io_oe, io_out}), int'({1'b1, 4'h0}));
    if (bus_stb) begin
      chk("beat_dir", int'(bus_rw), int'(exp_write));
      chk("beat_oe", int'(io_oe), int'(exp_write));
      if (bus_rw) chk("wr_nibble", int'(io_out), int'(sl_beat == 0 ? exp_wdata[3:0] : exp_wdata[7:4]));
    end
    if (rst || cmd_ready) begin
      sl_beat = 0;
      sl_wait = 0;
    end
    io_in = 4'($urandom);
    if (bus_stb && !rst) begin
      if (sl_wait >= sl_stall[sl_beat]) begin
        bus_ack = 1'b1;
        if (!bus_rw) io_in = sl_nib[sl_beat];
        sl_beat = 1;
        sl_wait = 0;
      end else begin
        bus_ack = 1'b0;
        sl_wait++;
      end
    end else begin
      bus_ack = 1'($urandom);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cmd_ready && k < 400) begin tick(); k++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (cyc < exp_rsp && k < 400) begin tick(); k++; end
    if (cyc < exp_rsp) chk("rsp_timeout", cyc, exp_rsp);
    wait_ready();
  endtask

  task automatic reset_pulse(input int n);
    int a;
    a        = cyc;
    rst      = 1'b1;
    cmd_valid = 1'b0;
    exp_rsp  = -1;
    zero_cyc = a + 1;
    oe_lo    = a + 1;
    oe_hi    = a + n + TURN - 1;
    oe_exp   = 1'b0;
    rdy_cyc  = a + n + TURN;
    repeat (n) tick();
    rst = 1'b0;
    wait_ready();
  endtask

  task automatic issue(input logic w, input logic [7:0] d, input int s0, input int s1, input logic hold);
    logic [3:0] n0, n1;
    logic ab0, ab1;
    int b0, b1, k;
    n0 = 4'($urandom);
    n1 = 4'($urandom);
    cmd_write = w;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 400) begin tick(); k++; end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (exp_acc >= 0) chk("b2b_accept", acc_cyc, exp_acc);
    exp_acc = -1;
    ab0 = 1'b0;
    ab1 = 1'b0;
`ifdef BIDIR_BUS_TIMEOUT_EN
    ab0 = (s0 >= int'(TIMEOUT));
    ab1 = !ab0 && (s1 >= int'(TIMEOUT));
`endif
    b0 = ab0 ? int'(TIMEOUT) : s0 + 1;
    b1 = ab0 ? 0 : (ab1 ? int'(TIMEOUT) : s1 + 1);
    exp_write = w;
    exp_wdata = d;
    exp_err   = ab0 | ab1;
    exp_rdata = (w || exp_err) ? 8'h00 : {n1, n0};
    exp_rsp   = w ? acc_cyc + 1 + b0 + b1 : acc_cyc + 2 * int'(TURN) + 1 + b0 + b1;
    oe_lo     = acc_cyc + 1;
    oe_hi     = w ? exp_rsp : exp_rsp - 1;
    oe_exp    = w;
    sl_stall[0] = s0;
    sl_stall[1] = s1;
    sl_nib[0]   = n0;
    sl_nib[1]   = n1;
    tick();
    if (!hold) cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic h;
    sl_stall[0] = 0; sl_stall[1] = 0;
    sl_nib[0] = 4'h0; sl_nib[1] = 4'h0;

    reset_pulse(3);

    // Write 0xA5 with ack always high: response three cycles after accept.
    issue(1'b1, 8'hA5, 0, 0, 1'b0);
    exp_rsp = acc_cyc + 3;
    wait_done();

    // Read with two stall cycles per beat, slave returns 0x3 then 0xC.
    issue(1'b0, 8'h00, 2, 2, 1'b0);
    sl_nib[0] = 4'h3;
    sl_nib[1] = 4'hC;
    exp_rdata = 8'hC3;
    exp_rsp   = acc_cyc + 11;
    wait_done();

    // Back-to-back writes with cmd_valid held.
    issue(1'b1, 8'h3C, 1, 0, 1'b1);
    exp_acc = exp_rsp + 1;
    issue(1'b1, 8'h96, 0, 2, 1'b0);
    wait_done();

    // Reset while the high read beat is stalled.
    issue(1'b0, 8'h00, 0, 1000, 1'b0);
    k = 0;
    while (sl_beat != 1 && k < 100) begin tick(); k++; end
    if (sl_beat != 1) chk("reach_rd_hi", sl_beat, 1);
    tick();
    tick();
    reset_pulse(1);

`ifdef BIDIR_BUS_TIMEOUT_EN
    // Read with no ack: abort after TIMEOUT stalls plus the turnaround back.
    issue(1'b0, 8'h00, 1000, 1000, 1'b0);
    exp_rsp = acc_cyc + 20;
    wait_done();
    issue(1'b1, 8'h5A, 0, 1000, 1'b0);
    wait_done();
`endif

    // Randomized mix of reads/writes, stalls and held cmd_valid.
    for (int i = 0; i < 40; i++) begin
      h = (i != 39) && ($urandom_range(0, 2) == 0);
      issue(1'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), h);
      if (h) exp_acc = exp_rsp + 1;
      else   wait_done();
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bidir_bus_ctrl.md
# bidir_bus_ctrl

Master-side sequencer for the shared half-duplex bidirectional pin bus between master and slave chips. Accepts byte-wide read/write commands from internal logic and moves each byte as two nibble beats over the tristate pins. Owns the pad output-enable, guaranteeing turnaround gaps so both chips never drive the bus together. Sits between the master's internal command source and the pad tristate buffer (pin driven when `io_oe`, `io_in` read back from the pin).

## Interface
- `WIDTH`, 4: pin bus width; data bytes are 2*WIDTH bits.
- `TURN`, 1: turnaround cycles with bus undriven, legal 1..7.
- `TIMEOUT`, 15: max cycles a beat waits for `bus_ack` (timeout build only).

Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_wdata`  in  2*WIDTH  write byte
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  2*WIDTH  read byte; 0 for writes and errors
- `rsp_err`  out  1  beat timed out (valid with `rsp_valid`)
- `bus_stb`  out  1  beat strobe to slave
- `bus_rw`  out  1  1 = master drives, 0 = slave drives
- `bus_ack`  in  1  slave beat acknowledge
- `io_out`  out  WIDTH  value to drive on pins
- `io_oe`  out  1  pad output enable
- `io_in`  in  WIDTH  pin readback

## Operation
- States: TURN_BACK, IDLE, WR_LO, WR_HI, TURN_RD, RD_LO, RD_HI, DONE.
- Reset state TURN_BACK, so pins stay released TURN cycles; covers reset mid-read while slave drives.
- IDLE: bus parked master-driven, `io_oe`=1, `io_out`=0, `cmd_ready`=1. `cmd_ready` low in all other states.
- Accept: write -> WR_LO; read -> TURN_RD. Command fields latched at accept.
- WR_LO/WR_HI: `io_oe`=1, `bus_stb`=1, `bus_rw`=1, `io_out` = low/high nibble. Beat completes on cycle with `bus_ack`=1; WR_LO -> WR_HI -> DONE.
- TURN_RD: `io_oe`=0, `bus_stb`=0 for TURN cycles -> RD_LO.
- RD_LO/RD_HI: `io_oe`=0, `bus_stb`=1, `bus_rw`=0; on `bus_ack` capture `io_in` into low/high nibble; RD_HI -> TURN_BACK -> DONE.
- TURN_BACK: `io_oe`=0, TURN cycles, then IDLE (after reset) or DONE (after read).
- DONE: `rsp_valid`=1 one cycle, `io_oe`=1 driving 0, -> IDLE.
- `bus_ack` ignored outside beat states. `io_oe`=1 is never permitted in TURN_RD, RD_LO, RD_HI, TURN_BACK.

## Timing
- All outputs registered from state; reset values all 0 (`cmd_ready`, `rsp_*`, `bus_*`, `io_out`, `io_oe`).
- After reset release: IDLE with `io_oe`=1 on cycle TURN+1.
- Write, ack immediate, accept cycle N: WR_LO N+1, WR_HI N+2, `rsp_valid` N+3, `cmd_ready` N+4.
- Read, ack immediate, TURN=1: TURN_RD N+1, RD_LO N+2, RD_HI N+3, TURN_BACK N+4, `rsp_valid` N+5.
- Each extra TURN cycle adds one cycle per turnaround; each ack-stall cycle adds one.
- `rst` in any state: next cycle TURN_BACK, outputs at reset values, no `rsp_valid` for the aborted command.

## Configuration
- `BIDIR_BUS_TIMEOUT_EN` defined: per-beat counter cleared on beat entry, counts stall cycles; TIMEOUT cycles without ack aborts. Write abort -> DONE; read abort -> TURN_BACK -> DONE; `rsp_err`=1, `rsp_rdata`=0.
- Undefined: beats wait indefinitely; `rsp_err` tied 0; no counter logic.

## Structure
- Package `bidir_bus_pkg`: state enum, default WIDTH/TURN/TIMEOUT constants.
- One sub-module `bus_turn_timer`: loadable down-counter with `done` flag, shared by turnaround and timeout counting.

## Test plan
- Reset, then idle: `io_oe`=0 for TURN cycles, then 1 with `io_out`=0, `cmd_ready`=1.
- Write 0xA5, ack always high: beats `io_out`=0x5 then 0xA; `rsp_valid` 3 cycles after accept, `rsp_err`=0.
- Read, TURN=2, slave returns 0x3 then 0xC with 2 stall cycles each: `rsp_rdata`=0xC3; `io_oe`=0 throughout read and both turnaround windows.
- Timeout build, read, ack never asserted: `rsp_err`=1, `rsp_rdata`=0 after TIMEOUT stall cycles plus TURN_BACK; next command accepted.
- `rst` asserted during RD_HI: `io_oe` stays 0 for TURN cycles after reset, no `rsp_valid`.
- Back-to-back writes with `cmd_valid` held: second accepted on first cycle back in IDLE; no overlap of `bus_stb` beats.
